// File: rtl/chan_scan_pkg.sv
// rtl/chan_scan_pkg.sv - shared types and constants for the channel scan mux
//
// Purpose : state encoding, mode constants and the channel-index width helper
//           used by chan_scan_mux and rr_next_chan.
// Ports   : none (package).
// Config  : CHAN_MASK_EN (optional per-channel enable mask) is handled in the
//           modules that import this package.
package chan_scan_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width for n items, never narrower than one bit so a single-channel
  // build still has a legal select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_chan.sv
// rtl/rr_next_chan.sv - round-robin search for the channel after the current one
//
// Purpose : combinational next-channel lookup for the auto-scan advance.
// Ports   : chan       in  SEL_W     currently shown channel
//           chan_mask  in  CHANNELS  enable per channel (CHAN_MASK_EN only)
//           next_chan  out SEL_W     next channel to show
// Config  : CHAN_MASK_EN - with it, the search skips disabled channels and
//           returns chan when none is enabled; without it, chan+1 with wrap.
module rr_next_chan
  import chan_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [SEL_W-1:0]    chan,
`ifdef CHAN_MASK_EN
  input  logic [CHANNELS-1:0] chan_mask,
`endif
  output logic [SEL_W-1:0]    next_chan
);

`ifdef CHAN_MASK_EN
  // Walk offsets from farthest to nearest so the nearest enabled channel in
  // ascending (wrapping) order wins. Offset CHANNELS lands back on chan, so a
  // lone enabled current channel is re-selected and an empty mask holds chan.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx       = '0;
    next_chan = chan;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = SEL_W'((32'(chan) + 32'(k)) % 32'(CHANNELS));
      if (chan_mask[idx]) begin
        next_chan = idx;
      end
    end
  end
`else
  assign next_chan = (32'(chan) == 32'(CHANNELS - 1)) ? '0 : chan + SEL_W'(1);
`endif

endmodule

// File: rtl/chan_scan_mux.sv
// rtl/chan_scan_mux.sv - manual / auto-scan selector of CHANNELS sources
//
// Purpose : puts one of CHANNELS WIDTH-bit sources on a registered output,
//           either chosen by sel (manual) or rotated every DWELL cycles (scan).
// Ports   : clk       in  1                 rising-edge clock
//           rst       in  1                 asynchronous active-low reset
//           mode      in  1                 0 manual, 1 auto-scan
//           sel       in  SEL_W             manual channel select
//           hold      in  1                 freeze all state while high
//           data_in   in  CHANNELS*WIDTH    channel k at [k*WIDTH +: WIDTH]
//           chan_mask in  CHANNELS          channel enables (CHAN_MASK_EN only)
//           result    out WIDTH             registered selected data
//           chan      out SEL_W             channel currently shown
//           switched  out 1                 one-cycle pulse when chan changes
// Config  : CHAN_MASK_EN - adds chan_mask; disabled channels read as zero and
//           are skipped by the scan.
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter  int WIDTH    = 3,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 8,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
`ifdef CHAN_MASK_EN
  input  logic [CHANNELS-1:0]       chan_mask,
`endif
  output logic [WIDTH-1:0]          result,
  output logic [SEL_W-1:0]          chan,
  output logic                      switched
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_chan;
  logic [WIDTH-1:0] r_result;
  logic             r_switched;

  logic [WIDTH-1:0] w_ch [CHANNELS];
  logic [SEL_W-1:0] w_rr_next;
  logic [SEL_W-1:0] w_sel_chan;
  logic [SEL_W-1:0] w_next_chan;
  logic [CNT_W-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_next_result;
  state_t           w_next_state;
  logic             w_sel_ok;
  logic             w_dwell_end;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign w_ch[k] = data_in[k*WIDTH +: WIDTH];
  end

  rr_next_chan #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_next_chan (
    .chan      (r_chan),
`ifdef CHAN_MASK_EN
    .chan_mask (chan_mask),
`endif
    .next_chan (w_rr_next)
  );

  // A select beyond the last channel is ignored: the current channel stays.
  assign w_sel_ok    = 32'(sel) < 32'(CHANNELS);
  assign w_sel_chan  = w_sel_ok ? sel : r_chan;
  assign w_dwell_end = 32'(r_cnt) == 32'(DWELL - 1);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_chan  = r_chan;
    case (r_state)
      ST_MANUAL: begin
        if (mode == MODE_SCAN) begin
          // Scan starts from whatever channel is already on show.
          w_next_state = ST_SCAN;
          w_next_cnt   = '0;
        end else begin
          w_next_chan = w_sel_chan;
        end
      end
      ST_SCAN: begin
        if (mode == MODE_MANUAL) begin
          w_next_state = ST_MANUAL;
          w_next_cnt   = '0;
          w_next_chan  = w_sel_chan;
        end else if (w_dwell_end) begin
          w_next_cnt  = '0;
          w_next_chan = w_rr_next;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_MANUAL;
      end
    endcase
  end

  // result follows the live data of the channel that will be on show, so a
  // source change reaches the output one edge later even mid-dwell.
`ifdef CHAN_MASK_EN
  assign w_next_result = chan_mask[w_next_chan] ? w_ch[w_next_chan] : '0;
`else
  assign w_next_result = w_ch[w_next_chan];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_MANUAL;
      r_cnt      <= '0;
      r_chan     <= '0;
      r_result   <= '0;
      r_switched <= 1'b0;
    end else if (hold) begin
      // Everything freezes; only the change pulse is forced low.
      r_switched <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_chan     <= w_next_chan;
      r_result   <= w_next_result;
      r_switched <= (w_next_chan != r_chan);
    end
  end

  assign result   = r_result;
  assign chan     = r_chan;
  assign switched = r_switched;

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb/tb_chan_scan_mux.sv - table-driven scoreboard bench for chan_scan_mux
module tb_chan_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        hold = 1'b0;
  logic [11:0] data_in = '0;
  logic [3:0]  mask = 4'hF;
  logic [2:0]  result;
  logic [1:0]  chan;
  logic        switched;

  logic        m3_mode = 1'b0;
  logic [1:0]  m3_sel = 2'd0;
  logic        m3_hold = 1'b0;
  logic [8:0]  m3_data = {3'd6, 3'd5, 3'd3};
  logic [2:0]  mask3 = 3'b111;
  logic [2:0]  res3;
  logic [1:0]  chan3;
  logic        sw3;

  always #5 clk = ~clk;

  chan_scan_mux #(.WIDTH(3), .CHANNELS(4), .DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .hold(hold), .data_in(data_in),
`ifdef CHAN_MASK_EN
    .chan_mask(mask),
`endif
    .result(result), .chan(chan), .switched(switched)
  );

  chan_scan_mux #(.WIDTH(3), .CHANNELS(3), .DWELL(4)) u_dut3 (
    .clk(clk), .rst(rst), .mode(m3_mode), .sel(m3_sel), .hold(m3_hold), .data_in(m3_data),
`ifdef CHAN_MASK_EN
    .chan_mask(mask3),
`endif
    .result(res3), .chan(chan3), .switched(sw3)
  );

  typedef struct {
    bit          rst_before;
    logic        mode;
    logic [1:0]  sel;
    logic        hold;
    logic [11:0] data;
    logic [3:0]  mask;
    logic [1:0]  exp_chan;
    logic [2:0]  exp_res;
    logic        exp_sw;
  } vec_t;

  typedef struct {
    logic [1:0] chan;
    logic [2:0] res;
    logic       sw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ch0=1 ch1=2 ch2=5 ch3=4, and variants
  localparam logic [11:0] D0  = {3'd4, 3'd5, 3'd2, 3'd1};
  localparam logic [11:0] D0X = {3'd4, 3'd7, 3'd2, 3'd1};
  localparam logic [11:0] D1  = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [11:0] D1L = {3'd4, 3'd3, 3'd6, 3'd1};
  localparam logic [11:0] D2  = {3'd7, 3'd7, 3'd7, 3'd7};

  function automatic void add(bit r, logic md, logic [1:0] s, logic h, logic [11:0] d,
                              logic [3:0] mk, logic [1:0] ec, logic [2:0] er, logic es);
    vec_t v;
    v.rst_before = r; v.mode = md; v.sel = s; v.hold = h; v.data = d; v.mask = mk;
    v.exp_chan = ec; v.exp_res = er; v.exp_sw = es;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [1:0] c, input logic [2:0] r, input logic s);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".chan"}, int'(c), int'(e.chan));
      chk({tag, ".result"}, int'(r), int'(e.res));
      chk({tag, ".switched"}, int'(s), int'(e.sw));
    end
  endtask

  task automatic step3(input logic md, input logic [1:0] s, input logic [1:0] ec,
                       input logic [2:0] er, input logic es, input int n);
    exp_t e;
    m3_mode = md; m3_sel = s;
    e.chan = ec; e.res = er; e.sw = es;
    sb.push_back(e);
    @(posedge clk); #1;
    pop_cmp($sformatf("ch3_step%0d", n), chan3, res3, sw3);
  endtask

  initial begin
    exp_t e;
    // Manual select and data-change latency
    add(0, 0, 2'd1, 0, D0,  4'hF, 2'd1, 3'd2, 1);
    add(0, 0, 2'd0, 0, D0,  4'hF, 2'd0, 3'd1, 1);
    add(0, 0, 2'd2, 0, D0,  4'hF, 2'd2, 3'd5, 1);
    add(0, 0, 2'd2, 0, D0,  4'hF, 2'd2, 3'd5, 0);
    add(0, 0, 2'd2, 0, D0X, 4'hF, 2'd2, 3'd7, 0);
    add(0, 0, 2'd0, 0, D1,  4'hF, 2'd0, 3'd1, 1);
    // Scan through all four channels, wrapping 3 -> 0, stopping one cycle into the dwell
    for (int s = 0; s < 18; s++) begin
      add(0, 1, 2'd0, 0, D1, 4'hF, 2'((s / 4) % 4), 3'(((s / 4) % 4) + 1), (s > 0) && (s % 4 == 0));
    end
    // Hold: mode, sel and data changes must all be ignored
    for (int h = 0; h < 10; h++) begin
      add(0, (h < 3) ? 1'b0 : 1'b1, 2'(h % 4), 1, D2, 4'hF, 2'd0, 3'd1, 0);
    end
    add(0, 1, 2'd0, 0, D1,  4'hF, 2'd0, 3'd1, 0);
    add(0, 1, 2'd0, 0, D1,  4'hF, 2'd0, 3'd1, 0);
    add(0, 1, 2'd0, 0, D1,  4'hF, 2'd1, 3'd2, 1);
    add(0, 1, 2'd0, 0, D1L, 4'hF, 2'd1, 3'd6, 0);
    // Leave scan straight onto sel, then re-enter from channel 3
    add(0, 0, 2'd3, 0, D1,  4'hF, 2'd3, 3'd4, 1);
    add(0, 1, 2'd0, 0, D1,  4'hF, 2'd3, 3'd4, 0);
    add(0, 1, 2'd0, 0, D1,  4'hF, 2'd3, 3'd4, 0);
    // Asynchronous reset mid-scan, then manual select
    add(1, 0, 2'd2, 0, D1,  4'hF, 2'd2, 3'd3, 1);
    add(0, 0, 2'd3, 0, D1,  4'hF, 2'd3, 3'd4, 1);
`ifdef CHAN_MASK_EN
    add(0, 0, 2'd0, 0, D1,  4'hF, 2'd0, 3'd1, 1);
    add(0, 1, 2'd0, 0, D1,  4'hA, 2'd0, 3'd0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 0, D1, 4'hA, 2'd0, 3'd0, 0);
    add(0, 1, 2'd0, 0, D1,  4'hA, 2'd1, 3'd2, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 0, D1, 4'hA, 2'd1, 3'd2, 0);
    add(0, 1, 2'd0, 0, D1,  4'hA, 2'd3, 3'd4, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 0, D1, 4'hA, 2'd3, 3'd4, 0);
    add(0, 1, 2'd0, 0, D1,  4'hA, 2'd1, 3'd2, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd0, 0, D1, 4'h0, 2'd1, 3'd0, 0);
    add(0, 1, 2'd0, 0, D1,  4'h0, 2'd1, 3'd0, 0);
    add(0, 0, 2'd0, 0, D1,  4'hE, 2'd0, 3'd0, 1);
    add(0, 0, 2'd2, 0, D1,  4'hE, 2'd2, 3'd3, 1);
`endif

    // Reset held from time zero
    data_in = D0;
    #12;
    chk("reset.chan", int'(chan), 0);
    chk("reset.result", int'(result), 0);
    chk("reset.switched", int'(switched), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin
        #3;
        rst = 1'b0;
        #1;
        chk($sformatf("row%0d.async_rst.chan", i), int'(chan), 0);
        chk($sformatf("row%0d.async_rst.result", i), int'(result), 0);
        chk($sformatf("row%0d.async_rst.switched", i), int'(switched), 0);
        @(negedge clk);
        rst = 1'b1;
      end
      mode = vecs[i].mode; sel = vecs[i].sel; hold = vecs[i].hold;
      data_in = vecs[i].data; mask = vecs[i].mask;
      e.chan = vecs[i].exp_chan; e.res = vecs[i].exp_res; e.sw = vecs[i].exp_sw;
      sb.push_back(e);
      @(posedge clk); #1;
      pop_cmp($sformatf("row%0d", i), chan, result, switched);
    end

    // Three-channel instance: out-of-range select and three-way wrap
    step3(0, 2'd0, 2'd0, 3'd3, 0, 0);
    step3(0, 2'd2, 2'd2, 3'd6, 1, 1);
    step3(0, 2'd3, 2'd2, 3'd6, 0, 2);
    step3(0, 2'd3, 2'd2, 3'd6, 0, 3);
    step3(0, 2'd1, 2'd1, 3'd5, 1, 4);
    step3(1, 2'd0, 2'd1, 3'd5, 0, 5);
    for (int i = 0; i < 3; i++) step3(1, 2'd0, 2'd1, 3'd5, 0, 6 + i);
    step3(1, 2'd0, 2'd2, 3'd6, 1, 9);
    for (int i = 0; i < 3; i++) step3(1, 2'd0, 2'd2, 3'd6, 0, 10 + i);
    step3(1, 2'd0, 2'd0, 3'd3, 1, 13);

    chk("scoreboard.drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
